u41_wiring_eval: RTL and testbench

//  Inverse of the function-to-wiring lookup: takes a per-pin wiring configuration and

---
 rtl/u41_wiring_eval_pkg.sv | 29 ++
 rtl/u41_wiring_eval_if.sv | 26 ++
 rtl/u41_pin_mux.sv | 25 ++
 rtl/u41_wiring_eval.sv | 117 +++++++++++
 tb/tb_u41_wiring_eval.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/u41_wiring_eval_pkg.sv
// Shared constants, wiring codes and FSM states for the universal-gate wiring blocks.
// Also used by the wiring ROM side, so code values must stay stable.
package u41_pkg;

    localparam int NPINS  = 10;
    localparam int CODE_W = 3;
    localparam int NIN    = 4;
    localparam int NVEC   = 1 << NIN;
    localparam int PIN_W  = 4;

    localparam logic [CODE_W-1:0] CODE_X0   = 3'd0;
    localparam logic [CODE_W-1:0] CODE_X1   = 3'd1;
    localparam logic [CODE_W-1:0] CODE_X2   = 3'd2;
    localparam logic [CODE_W-1:0] CODE_X3   = 3'd3;
    localparam logic [CODE_W-1:0] CODE_ZERO = 3'd4;
    localparam logic [CODE_W-1:0] CODE_ONE  = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Codes above CODE_ONE have no meaning on the gate
    function automatic logic code_is_legal(input logic [CODE_W-1:0] code);
        return code <= CODE_ONE;
    endfunction

endpackage

// File: rtl/u41_wiring_eval_if.sv
// Load/start/result bus of the wiring evaluator plus its link to the external gate model.
interface u41_wiring_eval_if;
    import u41_pkg::*;

    logic                  load_valid;
    logic [PIN_W-1:0]      load_pin;
    logic [CODE_W-1:0]     load_code;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [NVEC-1:0]       func_out;
    logic                  err;
    logic [NPINS-1:0]      gate_in;
    logic                  gate_out;

    modport master (
        output load_valid, load_pin, load_code, start, gate_out,
        input  busy, done, func_out, err, gate_in
    );

    modport slave (
        input  load_valid, load_pin, load_code, start, gate_out,
        output busy, done, func_out, err, gate_in
    );

endinterface

// File: rtl/u41_pin_mux.sv
// Per-pin selector: turns a wiring code and the current input vector into the pin level.
module u41_pin_mux
    import u41_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    input  logic [NIN-1:0]    vec,
    output logic              pin_bit,
    output logic              illegal
);

    always_comb begin
        pin_bit = 1'b0;
        illegal = !code_is_legal(code);
        case (code)
            CODE_X0:   pin_bit = vec[0];
            CODE_X1:   pin_bit = vec[1];
            CODE_X2:   pin_bit = vec[2];
            CODE_X3:   pin_bit = vec[3];
            CODE_ZERO: pin_bit = 1'b0;
            CODE_ONE:  pin_bit = 1'b1;
            default:   pin_bit = 1'b0;
        endcase
    end

endmodule

// File: rtl/u41_wiring_eval.sv
// Recovers the truth table realised by a pin wiring by sweeping all input vectors
// through the external gate model, one vector per cycle.
module u41_wiring_eval
    import u41_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    u41_wiring_eval_if.slave    bus
);

    localparam logic [PIN_W-1:0] LAST_PIN = PIN_W'(NPINS - 1);
    localparam logic [NIN-1:0]   LAST_VEC = '1;

    state_t             state_reg, state_next;
    logic [NIN-1:0]     counter_reg, counter_next;
    logic [NVEC-1:0]    acc_reg, acc_next;
    logic [NVEC-1:0]    func_reg, func_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;

    logic [CODE_W-1:0]  wiring_reg [NPINS];
    logic [NPINS-1:0]   gate_vec;
    logic [NPINS-1:0]   illegal_vec;

    logic               load_pin_ok;
    logic               load_en;

    assign load_pin_ok = bus.load_pin <= LAST_PIN;
    assign load_en     = (state_reg == IDLE) && bus.load_valid && load_pin_ok;

    // Wiring slots only change in IDLE, so they are frozen for the whole sweep
    generate
        for (genvar gi = 0; gi < NPINS; gi++) begin : g_pin
            always_ff @(posedge clk) begin
                if (rst) begin
                    wiring_reg[gi] <= CODE_ZERO;
                end else if (load_en && (bus.load_pin == PIN_W'(gi))) begin
                    wiring_reg[gi] <= bus.load_code;
                end
            end

            u41_pin_mux u_mux (
                .code    (wiring_reg[gi]),
                .vec     (counter_reg),
                .pin_bit (gate_vec[gi]),
                .illegal (illegal_vec[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            counter_reg <= '0;
            acc_reg     <= '0;
            func_reg    <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            acc_reg     <= acc_next;
            func_reg    <= func_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        acc_next     = acc_reg;
        func_next    = func_reg;
        done_next    = 1'b0;
        err_next     = err_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next   = SWEEP;
                    counter_next = '0;
                    acc_next     = '0;
                    err_next     = 1'b0;
                end
                // A dropped load still flags even alongside a start
                if (bus.load_valid && !load_pin_ok) begin
                    err_next = 1'b1;
                end
            end
            SWEEP: begin
                acc_next[counter_reg] = bus.gate_out;
                counter_next          = counter_reg + 1'b1;
                if (|illegal_vec) begin
                    err_next = 1'b1;
                end
                if (counter_reg == LAST_VEC) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                func_next  = acc_reg;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_reg == SWEEP);
    assign bus.done     = done_reg;
    assign bus.func_out = func_reg;
    assign bus.err      = err_reg;
    assign bus.gate_in  = gate_vec;

endmodule

// File: tb/tb_u41_wiring_eval.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// and randomized wirings checked against an arithmetic truth-table model.
module tb_u41_wiring_eval;
    import u41_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    u41_wiring_eval_if bus();

    u41_wiring_eval dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Gate model: 0 -> pin0, 1 -> pin0 & pin1, 2 -> masked parity with optional invert
    int         gmode;
    logic [9:0] gmask;
    logic       ginv;

    always_comb begin
        case (gmode)
            1:       bus.gate_out = bus.gate_in[0] & bus.gate_in[1];
            2:       bus.gate_out = (^(bus.gate_in & gmask)) ^ ginv;
            default: bus.gate_out = bus.gate_in[0];
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic load(input int pin, input int code);
        bus.load_valid = 1'b1;
        bus.load_pin   = 4'(pin);
        bus.load_code  = 3'(code);
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
    endtask

    // Pulse start and wait (bounded) for done; lat = edges from start edge to done seen
    task automatic sweep(output logic [15:0] f, output logic e, output int lat);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        f = bus.func_out;
        e = bus.err;
    endtask

    // Reference: evaluate each pin from its code, then the gate function, per vector
    int ref_codes [10];

    function automatic logic [15:0] ref_func();
        logic [15:0] r;
        logic [9:0]  g;
        r = '0;
        for (int v = 0; v < 16; v++) begin
            for (int p = 0; p < 10; p++) begin
                if (ref_codes[p] < 4) g[p] = ((v >> ref_codes[p]) & 1) != 0;
                else                  g[p] = (ref_codes[p] == 5);
            end
            r[v] = (^(g & gmask)) ^ ginv;
        end
        return r;
    endfunction

    function automatic logic ref_err();
        logic e;
        e = 1'b0;
        for (int p = 0; p < 10; p++) if (ref_codes[p] >= 6) e = 1'b1;
        return e;
    endfunction

    typedef struct {
        string       name;
        int          c0;
        int          c1;
        int          mode;
        logic [15:0] f;
        logic        e;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [15:0] f;
        logic        e;
        int          lat;
        int          seen;

        tbl[0] = '{"x0",       0, 4, 0, 16'hAAAA, 1'b0};
        tbl[1] = '{"x3",       3, 4, 0, 16'hFF00, 1'b0};
        tbl[2] = '{"one",      5, 4, 0, 16'hFFFF, 1'b0};
        tbl[3] = '{"zero",     4, 4, 0, 16'h0000, 1'b0};
        tbl[4] = '{"and_x0x1", 0, 1, 1, 16'h8888, 1'b0};
        tbl[5] = '{"illegal6", 6, 4, 0, 16'h0000, 1'b1};
        tbl[6] = '{"recover",  0, 4, 0, 16'hAAAA, 1'b0};

        rst = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_pin   = '0;
        bus.load_code  = '0;
        bus.start      = 1'b0;
        gmode = 0;
        gmask = '0;
        ginv  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_busy",    32'(bus.busy),     32'd0);
        chk("reset_done",    32'(bus.done),     32'd0);
        chk("reset_func",    32'(bus.func_out), 32'd0);
        chk("reset_err",     32'(bus.err),      32'd0);
        chk("reset_gate_in", 32'(bus.gate_in),  32'd0);

        for (int i = 0; i < 7; i++) begin
            gmode = tbl[i].mode;
            load(0, tbl[i].c0);
            load(1, tbl[i].c1);
            sweep(f, e, lat);
            $display("table %s: func=%h err=%b latency=%0d", tbl[i].name, f, e, lat);
            chk({tbl[i].name, "_latency"}, 32'(lat), 32'd17);
            chk({tbl[i].name, "_func"},    32'(f),   32'(tbl[i].f));
            chk({tbl[i].name, "_err"},     32'(e),   32'(tbl[i].e));
            @(posedge clk);
            #1;
            chk({tbl[i].name, "_done_pulse"}, 32'(bus.done), 32'd0);
        end

        // Load and start during a sweep must both be ignored
        gmode = 0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n == 3) begin
                bus.load_valid = 1'b1;
                bus.load_pin   = 4'd0;
                bus.load_code  = 3'd5;
                bus.start      = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.load_valid = 1'b0;
            bus.start      = 1'b0;
            if (n == 3) chk("midsweep_busy", 32'(bus.busy), 32'd1);
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        $display("midsweep: func=%h latency=%0d", bus.func_out, lat);
        chk("midsweep_latency", 32'(lat),          32'd17);
        chk("midsweep_func",    32'(bus.func_out), 32'hAAAA);
        @(posedge clk);
        #1;
        chk("midsweep_no_queue", 32'(bus.busy), 32'd0);
        sweep(f, e, lat);
        $display("after midsweep: func=%h latency=%0d", f, lat);
        chk("after_midsweep_func", 32'(f), 32'hAAAA);

        // Reset mid-sweep aborts with no done pulse
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("reset mid-sweep: busy=%b func=%h gate_in=%h", bus.busy, bus.func_out, bus.gate_in);
        chk("abort_busy",    32'(bus.busy),     32'd0);
        chk("abort_done",    32'(bus.done),     32'd0);
        chk("abort_func",    32'(bus.func_out), 32'd0);
        chk("abort_gate_in", 32'(bus.gate_in),  32'd0);
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        // Out-of-range pin: dropped, err set, every slot still const 0
        load(12, 5);
        $display("load pin 12: err=%b", bus.err);
        chk("bad_pin_err", 32'(bus.err), 32'd1);
        gmode = 2;
        gmask = 10'h3FF;
        ginv  = 1'b0;
        sweep(f, e, lat);
        $display("after bad pin: func=%h err=%b", f, e);
        chk("bad_pin_slots", 32'(f), 32'h0000);
        chk("bad_pin_err_cleared", 32'(e), 32'd0);

        // Randomized wirings against the reference model
        for (int it = 0; it < 25; it++) begin
            gmask = 10'($urandom);
            ginv  = 1'($urandom);
            for (int p = 0; p < 10; p++) begin
                if ($urandom_range(0, 11) == 0) ref_codes[p] = 6 + int'($urandom_range(0, 1));
                else                            ref_codes[p] = int'($urandom_range(0, 5));
                load(p, ref_codes[p]);
            end
            sweep(f, e, lat);
            $display("random %0d: mask=%h inv=%b func=%h exp=%h err=%b",
                     it, gmask, ginv, f, ref_func(), e);
            chk("rand_latency", 32'(lat), 32'd17);
            chk("rand_func",    32'(f),   32'(ref_func()));
            chk("rand_err",     32'(e),   32'(ref_err()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
